// File: rtl/i2s_out_pkg.sv
// Shared types and helpers for the stereo I2S/LJ/RJ transmitter.
package i2s_out_pkg;

  typedef enum logic [1:0] {
    MODE_I2S     = 2'd0,
    MODE_LEFT_J  = 2'd1,
    MODE_RIGHT_J = 2'd2
  } i2s_mode_e;

  function automatic bit slot_w_legal(int w);
    return (w == 16) || (w == 24) || (w == 32);
  endfunction

  // Sample bit carried at slot position p, or -1 for a zero bit. In I2S mode
  // p = 0 refers to the previous slot's channel, not the current one.
  function automatic int slot_bit_idx(int p, int mode, int in_res, int slot_w);
    int q;
    if (mode == int'(MODE_RIGHT_J)) begin
      return (p < slot_w - in_res) ? in_res - 1 : slot_w - 1 - p;
    end
    if (mode == int'(MODE_I2S)) begin
      if (p == 0) begin
        return (in_res == slot_w) ? 0 : -1;
      end
      q = p - 1;
    end else begin
      q = p;
    end
    return (q < in_res) ? in_res - 1 - q : -1;
  endfunction

endpackage

// File: rtl/i2s_audio_out_stereo_clk_gen.sv
// Phase / bit-index counters and the registered serial clocks derived from them.
module i2s_clk_gen
#(
  parameter  int BCLK_DIV = 16,
  parameter  int SLOT_W   = 32,
  localparam int PW       = $clog2(BCLK_DIV),
  localparam int BW       = $clog2(2 * SLOT_W)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          mclk,
  output logic          bclk,
  output logic          lrclk,
  output logic          tick,
  output logic          frame_load,
  output logic [BW-1:0] b_next
);

  localparam logic [PW-1:0] PH_MAX   = PW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] B_MAX    = BW'(2 * SLOT_W - 1);
  localparam int            MCLK_DIV = BCLK_DIV / 4;

  logic [PW-1:0] ph_q, ph_d;
  logic [BW-1:0] b_q, b_d;
  logic          bclk_q, bclk_d;
  logic          lrclk_q, lrclk_d;

  // Clock outputs are registered from the next counter value so they line up
  // exactly with the counter state seen by the data path.
  always_comb begin
    tick       = (ph_q == PH_MAX);
    ph_d       = tick ? '0 : ph_q + 1'b1;
    b_next     = (b_q == B_MAX) ? '0 : b_q + 1'b1;
    b_d        = tick ? b_next : b_q;
    frame_load = tick && (b_q == B_MAX);
    bclk_d     = (ph_d >= PW'(BCLK_DIV / 2));
    lrclk_d    = (b_d >= BW'(SLOT_W));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q    <= '0;
      b_q     <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      b_q     <= b_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
    end
  end

  assign bclk  = bclk_q;
  assign lrclk = lrclk_q;

  if (MCLK_DIV == 1) begin : g_mclk_pass
    assign mclk = clk;
  end else begin : g_mclk_div
    logic mclk_q, mclk_d;
    always_comb mclk_d = (int'(ph_d) % MCLK_DIV) >= (MCLK_DIV / 2);
    always_ff @(posedge clk) begin
      if (reset) mclk_q <= 1'b0;
      else       mclk_q <= mclk_d;
    end
    assign mclk = mclk_q;
  end

endmodule

// File: rtl/i2s_audio_out_stereo.sv
// Stereo I2S/LJ/RJ transmitter: one-entry sample buffer, per-frame registers, serial data.
// Build option I2S_OUT_UNDERRUN_ZERO_EN: an underrun loads silence instead of repeating the frame.
module i2s_audio_out_stereo
  import i2s_out_pkg::*;
#(
  parameter int IN_RES   = 16,
  parameter int SLOT_W   = 32,
  parameter int MODE     = 0,
  parameter int BCLK_DIV = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_RES-1:0] in_left,
  input  logic [IN_RES-1:0] in_right,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mute,
  output logic              mclk,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              frame_start,
  output logic              underrun
);

  localparam int BW = $clog2(2 * SLOT_W);

  if (!slot_w_legal(SLOT_W)) begin : g_bad_slot
    $error("SLOT_W must be 16, 24 or 32");
  end
  if (IN_RES < 1 || IN_RES > SLOT_W) begin : g_bad_res
    $error("IN_RES must be in 1..SLOT_W");
  end
  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("MODE must be 0, 1 or 2");
  end
  if (BCLK_DIV < 4 || (BCLK_DIV % 4) != 0) begin : g_bad_div
    $error("BCLK_DIV must be a multiple of 4 and at least 4");
  end

  logic          tick, frame_load;
  logic [BW-1:0] b_next;

  i2s_clk_gen #(.BCLK_DIV(BCLK_DIV), .SLOT_W(SLOT_W)) u_clk_gen (
    .clk        (clk),
    .reset      (reset),
    .mclk       (mclk),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .tick       (tick),
    .frame_load (frame_load),
    .b_next     (b_next)
  );

  logic              hold_full_q, hold_full_d;
  logic [IN_RES-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [IN_RES-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic              ready_q, ready_d;
  logic              sdata_q, sdata_d;
  logic              frame_start_q, frame_start_d;
  logic              underrun_q, underrun_d;
  logic              xfer, right_slot, bit_v;
  logic [IN_RES-1:0] chan;
  int                p_pos, bit_idx;

  always_comb begin
    xfer      = in_valid && ready_q;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    if (xfer) begin
      hold_l_d = in_left;
      hold_r_d = in_right;
    end
    hold_full_d = (hold_full_q && !frame_load) || xfer;
    ready_d     = !hold_full_d;

    frame_l_d = frame_l_q;
    frame_r_d = frame_r_q;
    if (frame_load) begin
      if (hold_full_q) begin
        frame_l_d = hold_l_q;
        frame_r_d = hold_r_q;
      end else begin
`ifdef I2S_OUT_UNDERRUN_ZERO_EN
        frame_l_d = '0;
        frame_r_d = '0;
`endif
      end
      // Mute wins over fresh data, but the buffer above is still consumed.
      if (mute) begin
        frame_l_d = '0;
        frame_r_d = '0;
      end
    end
    frame_start_d = frame_load;
    underrun_d    = frame_load && !hold_full_q;

    // Select the bit for the position entered at this tick; the I2S lead-in bit
    // comes from the slot just finished, hence the pre-load frame registers.
    right_slot = (b_next >= BW'(SLOT_W));
    p_pos      = int'(b_next) - (right_slot ? SLOT_W : 0);
    bit_idx    = slot_bit_idx(p_pos, MODE, IN_RES, SLOT_W);
    if (MODE == int'(MODE_I2S) && p_pos == 0) chan = right_slot ? frame_l_q : frame_r_q;
    else                                      chan = right_slot ? frame_r_d : frame_l_d;
    bit_v = 1'b0;
    for (int i = 0; i < IN_RES; i++) begin
      if (i == bit_idx) bit_v = chan[i];
    end
    sdata_d = tick ? bit_v : sdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full_q   <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      frame_l_q     <= '0;
      frame_r_q     <= '0;
      ready_q       <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      hold_full_q   <= hold_full_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      frame_l_q     <= frame_l_d;
      frame_r_q     <= frame_r_d;
      ready_q       <= ready_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign in_ready    = ready_q;
  assign sdata       = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_audio_out_stereo.sv
// Scoreboard bench: three transmitters (I2S, LJ, RJ) share one stimulus stream.
module tb_i2s_audio_out_stereo;

  localparam int IN_RES   = 16;
  localparam int SLOT_W   = 32;
  localparam int BCLK_DIV = 16;
  localparam int FRAME    = 2 * SLOT_W * BCLK_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_left = '0, in_right = '0;
  logic        in_valid = 1'b0, mute = 1'b0;
  logic [2:0]  in_ready, mclk, bclk, lrclk, sdata, frame_start, underrun;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    i2s_audio_out_stereo #(
      .IN_RES(IN_RES), .SLOT_W(SLOT_W), .MODE(m), .BCLK_DIV(BCLK_DIV)
    ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_left     (in_left),
      .in_right    (in_right),
      .in_valid    (in_valid),
      .in_ready    (in_ready[m]),
      .mute        (mute),
      .mclk        (mclk[m]),
      .bclk        (bclk[m]),
      .lrclk       (lrclk[m]),
      .sdata       (sdata[m]),
      .frame_start (frame_start[m]),
      .underrun    (underrun[m])
    );
  end

  typedef struct packed {
    logic [15:0] pl, pr, cl, cr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, failures = 0;
  int          n = 0, loads = 0, epoch = 0;
  bit          m_full = 0, m_alive = 0, last_und = 0, last_xfer = 0;
  logic [15:0] m_hl = '0, m_hr = '0, m_cl = '0, m_cr = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Left-justified stream of one frame, index = bit position b in the frame.
  function automatic logic [63:0] lj_bits(logic [15:0] l, logic [15:0] r);
    logic [63:0] v;
    logic [15:0] s;
    for (int k = 0; k < 64; k++) begin
      s    = (k >= 32) ? r : l;
      v[k] = ((k % 32) < 16) ? s[15 - (k % 32)] : 1'b0;
    end
    return v;
  endfunction

  function automatic logic [63:0] exp_bits(int mode, exp_t e);
    logic [63:0] cur, prev, v;
    logic [15:0] s;
    int          p;
    cur  = lj_bits(e.cl, e.cr);
    prev = lj_bits(e.pl, e.pr);
    if (mode == 1) return cur;
    if (mode == 0) return {cur[62:0], prev[63]};
    for (int k = 0; k < 64; k++) begin
      s    = (k >= 32) ? e.cr : e.cl;
      p    = k % 32;
      v[k] = (p < 16) ? s[15] : s[31 - p];
    end
    return v;
  endfunction

  task automatic model_update();
    exp_t e;
    bit   xfer;
    last_xfer = 0;
    if (reset) begin
      n = 0; m_full = 0; m_alive = 0; m_cl = '0; m_cr = '0; last_und = 0;
      epoch++;
      sb.delete();
    end else begin
      xfer = in_valid && !m_full && m_alive;
      if (n % FRAME == FRAME - 1) begin
        e.pl = m_cl; e.pr = m_cr;
        last_und = !m_full;
        if (m_full) begin
          m_cl = m_hl; m_cr = m_hr; m_full = 0;
        end else begin
`ifdef I2S_OUT_UNDERRUN_ZERO_EN
          m_cl = '0; m_cr = '0;
`endif
        end
        if (mute) begin
          m_cl = '0; m_cr = '0;
        end
        e.cl = m_cl; e.cr = m_cr;
        sb.push_back(e);
        loads++;
      end
      if (xfer) begin
        m_full = 1; m_hl = in_left; m_hr = in_right; last_xfer = 1;
      end
      m_alive = 1;
      n++;
    end
  endtask

  task automatic check_outputs();
    int s, ph, b;
    bit fs;
    if (reset) begin
      chk("reset_outputs", 64'({in_ready, mclk, bclk, lrclk, sdata, frame_start, underrun}), 64'(0));
    end else begin
      s  = n % FRAME;
      ph = s % BCLK_DIV;
      b  = s / BCLK_DIV;
      fs = (s == 0) && (n > 0);
      chk("clocks", 64'({mclk, bclk, lrclk}),
          64'({{3{(ph % (BCLK_DIV / 4)) >= BCLK_DIV / 8}}, {3{ph >= BCLK_DIV / 2}}, {3{b >= SLOT_W}}}));
      chk("strobes", 64'({frame_start, underrun}), 64'({{3{fs}}, {3{fs && last_und}}}));
      chk("in_ready", 64'(in_ready), 64'({3{!m_full}}));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int k);
    repeat (k) cycle();
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    int guard = 0;
    in_left = l; in_right = r; in_valid = 1'b1;
    do begin
      cycle();
      guard++;
    end while (!last_xfer && guard < 3 * FRAME);
    chk("send_accepted", 64'(last_xfer), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic wait_loads(input int k);
    int target = loads + k;
    int guard  = 0;
    while (loads < target && guard < (k + 1) * FRAME) begin
      cycle();
      guard++;
    end
    chk("loads_reached", 64'(loads >= target), 64'(1));
  endtask

  // Monitor: each frame_start pops one expected frame and checks all 64 bits
  // of every instance, sampled mid-bit while bclk is high.
  initial begin
    exp_t        e;
    int          ep;
    logic [63:0] got [3];
    forever begin
      @(negedge clk);
      if (!reset && frame_start[0]) begin
        chk("frame_expected", 64'(sb.size() > 0), 64'(1));
        if (sb.size() > 0) begin
          e  = sb.pop_front();
          ep = epoch;
          for (int k = 0; k < 64; k++) begin
            repeat ((k == 0) ? BCLK_DIV / 2 : BCLK_DIV) @(negedge clk);
            for (int m = 0; m < 3; m++) got[m][k] = sdata[m];
          end
          if (ep == epoch) begin
            for (int m = 0; m < 3; m++)
              chk($sformatf("sdata_mode%0d", m), got[m], exp_bits(m, e));
          end
        end
      end
    end
  end

  initial begin
    int target;
    reset = 1'b1;
    run(4);
    reset = 1'b0;

    send(16'hA5C3, 16'h8001);
    send(16'h8000, 16'h7FFF);
    send(16'h1234, 16'h4321);
    wait_loads(3);

    in_valid = 1'b1;
    in_left  = 16'($urandom);
    in_right = 16'($urandom);
    target   = loads + 6;
    while (loads < target) begin
      cycle();
      if (last_xfer) begin
        in_left  = 16'($urandom);
        in_right = 16'($urandom);
      end
    end
    in_valid = 1'b0;

    target = loads + 8;
    while (loads < target) begin
      in_valid = ($urandom_range(0, 599) == 0);
      in_left  = 16'($urandom);
      in_right = 16'($urandom);
      if (n % 256 == 0) mute = ($urandom_range(0, 3) == 0);
      cycle();
    end
    in_valid = 1'b0;
    mute     = 1'b0;

    send(16'h5A5A, 16'hC3C3);
    mute = 1'b1;
    wait_loads(1);
    mute = 1'b0;

    send(16'h0F0F, 16'hF0F0);
    while ((n % FRAME) != FRAME / 2 + 200) cycle();
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    send(16'h7777, 16'h8888);
    wait_loads(3);

    run(FRAME - 5);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
